timer_alarm: RTL and testbench

Multi-channel compare/alarm controller that sequences the free-running 32-bit system timer into CPU interrupts. It sits on the picorv32 native memory bus next to the timer peripheral and watches the timer's count value. Software programs per-channel compare and period registers. The block raises a level interrupt on match and optionally re-arms itself periodically.

---
 rtl/timer_alarm_pkg.sv | 29 ++
 rtl/timer_alarm_chan.sv | 45 ++++
 rtl/timer_alarm.sv | 108 ++++++++++
 tb/tb_timer_alarm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_alarm_pkg.sv
// Shared constants and helpers for the timer compare/alarm controller.
package timer_alarm_pkg;

    localparam int NCH_MAX = 8;

    localparam logic [7:0] OFF_CTRL        = 8'h00;
    localparam logic [7:0] OFF_STATUS      = 8'h04;
    localparam logic [7:0] OFF_IRQEN       = 8'h08;
    localparam logic [7:0] OFF_CMP_BASE    = 8'h10;
    localparam logic [7:0] OFF_PERIOD_BASE = 8'h14;
    localparam logic [7:0] CH_STRIDE       = 8'h08;

    // Replace only the byte lanes selected by strb.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] chan_off(input int c, input logic is_period);
        return 8'(int'(is_period ? OFF_PERIOD_BASE : OFF_CMP_BASE) + c * int'(CH_STRIDE));
    endfunction

endpackage

// File: rtl/timer_alarm_chan.sv
// One compare channel: CMP/PERIOD registers, equality match, periodic reload
// and one-shot disarm.
module timer_alarm_chan
    import timer_alarm_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] count_in,
    input  logic        cmp_we,
    input  logic        period_we,
    input  logic        ctrl_we,
    input  logic        ctrl_wbit,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] cmp,
    output logic [31:0] period,
    output logic        armed,
    output logic        match
);

    assign match = armed && (count_in == cmp);

    // Software writes take priority over the reload/disarm of the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cmp    <= '0;
            period <= '0;
            armed  <= 1'b0;
        end else begin
            if (cmp_we)
                cmp <= merge_bytes(cmp, wdata, wstrb);
            else if (match && period != '0)
                cmp <= cmp + period;

            if (period_we)
                period <= merge_bytes(period, wdata, wstrb);

            if (ctrl_we)
                armed <= ctrl_wbit;
            else if (match && period == '0)
                armed <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_alarm.sv
// Multi-channel compare/alarm controller on the picorv32 native bus; turns
// timer count matches into a level interrupt.
module timer_alarm
    import timer_alarm_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic [31:0] count_in,
    output logic        irq
);

    logic            rdy;
    logic            accept;
    logic            wr_en;
    logic [7:0]      off;
    logic [31:0]     rdata_q;
    logic [31:0]     rdata_mux;
    logic [31:0]     irqen_merged;
    logic [NCH-1:0]  armed;
    logic [NCH-1:0]  match;
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  irq_en;
    logic [NCH-1:0]  clr;
    logic [NCH-1:0]  cmp_we;
    logic [NCH-1:0]  period_we;
    logic [NCH-1:0]  ctrl_we;
    logic [31:0]     cmp_val    [NCH];
    logic [31:0]     period_val [NCH];
    logic            unused_bus;

    assign unused_bus = &{1'b0, mem_instr, mem_addr[31:8], mem_addr[1:0], irqen_merged[31:NCH]};

    assign off    = {mem_addr[7:2], 2'b00};
    assign accept = mem_valid & enable & ~rdy;
    assign wr_en  = accept & (|mem_wstrb);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign cmp_we[c]    = wr_en && (off == chan_off(c, 1'b0));
        assign period_we[c] = wr_en && (off == chan_off(c, 1'b1));
        assign ctrl_we[c]   = wr_en && (off == OFF_CTRL) && mem_wstrb[0];

        timer_alarm_chan u_chan (
            .clk       (clk),
            .resetn    (resetn),
            .count_in  (count_in),
            .cmp_we    (cmp_we[c]),
            .period_we (period_we[c]),
            .ctrl_we   (ctrl_we[c]),
            .ctrl_wbit (mem_wdata[c]),
            .wdata     (mem_wdata),
            .wstrb     (mem_wstrb),
            .cmp       (cmp_val[c]),
            .period    (period_val[c]),
            .armed     (armed[c]),
            .match     (match[c])
        );
    end

    // Channel bits all live in byte lane 0, so only wstrb[0] gates the W1C.
    assign clr = (wr_en && off == OFF_STATUS && mem_wstrb[0]) ? mem_wdata[NCH-1:0] : '0;
    assign irqen_merged = merge_bytes(32'(irq_en), mem_wdata, mem_wstrb);

    always_comb begin
        rdata_mux = '0;
        if (off == OFF_CTRL)
            rdata_mux = 32'(armed);
        else if (off == OFF_STATUS)
            rdata_mux = 32'(pending);
        else if (off == OFF_IRQEN)
            rdata_mux = 32'(irq_en);
        for (int c = 0; c < NCH; c++) begin
            if (off == chan_off(c, 1'b0)) rdata_mux = cmp_val[c];
            if (off == chan_off(c, 1'b1)) rdata_mux = period_val[c];
        end
    end

    // A hardware set in the same cycle as a W1C wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdy     <= 1'b0;
            rdata_q <= '0;
            pending <= '0;
            irq_en  <= '0;
        end else begin
            rdy     <= accept;
            pending <= (pending & ~clr) | match;
            if (accept)
                rdata_q <= rdata_mux;
            if (wr_en && off == OFF_IRQEN)
                irq_en <= irqen_merged[NCH-1:0];
        end
    end

    assign mem_ready = enable & rdy;
    assign mem_rdata = enable ? rdata_q : '0;
    assign irq       = |(pending & irq_en);

endmodule

// File: tb/tb_timer_alarm.sv
// Scoreboard bench for timer_alarm: expected read data and match counts are
// queued when stimulus is issued and compared when the DUT responds.
module tb_timer_alarm;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] count_in;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    timer_alarm dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_instr (mem_instr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .count_in  (count_in),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // All inputs change on the falling edge; the timer advances once per clock.
    task automatic tick();
        @(negedge clk);
        count_in = count_in + 32'd1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        exp_t e;
        check("sb_depth", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int k;
        enable    = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        mem_wstrb = strb;
        k = 0;
        do begin
            tick();
            k++;
        end while (!mem_ready && k < 8);
        check("ready_latency", 32'(k), 32'd1);
        if (strb == 4'h0)
            pop_check(mem_rdata);
        // mem_valid stays high: ready must still drop for one cycle
        tick();
        check("ready_drop", 32'(mem_ready), 32'd0);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus(addr, data, strb);
    endtask

    task automatic rd(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        push_exp(tag, exp);
        bus(addr, 32'h0, 4'h0);
    endtask

    // cp holds the count seen at the edge just before irq was observed high.
    task automatic wait_irq(input int budget);
        logic [31:0] cp;
        int k;
        k  = 0;
        cp = count_in;
        while (!irq && k < budget) begin
            cp = count_in;
            tick();
            k++;
        end
        check("irq_seen", 32'(irq), 32'd1);
        pop_check(cp);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        enable    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        mem_addr  = 32'h0;
        repeat (3) tick();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        count_in = 32'd0;
        do_reset();

        // reset state and full address sweep
        enable = 1'b1;
        #1;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 'h80; a += 4)
            rd(32'(a), "rst_read", 32'd0);

        // bits above NCH and unmapped offsets
        wr(32'h30, 32'hFFFF_FFFF, 4'hF);
        wr(32'h00, 32'h0000_00F0, 4'hF);
        wr(32'h08, 32'hFFFF_FFFF, 4'hF);
        rd(32'h30, "unmapped_read", 32'd0);
        rd(32'h00, "ctrl_high_bits", 32'd0);
        rd(32'h08, "irqen_width", 32'h0000_000F);

        // one-shot on channel 0
        do_reset();
        count_in = 32'd90;
        wr(32'h10, 32'd100, 4'hF);
        wr(32'h14, 32'd0, 4'hF);
        wr(32'h08, 32'd1, 4'hF);
        push_exp("oneshot_match_count", 32'd100);
        wr(32'h00, 32'd1, 4'hF);
        wait_irq(40);
        rd(32'h00, "oneshot_ctrl", 32'd0);
        rd(32'h04, "oneshot_status", 32'd1);
        rd(32'h10, "oneshot_cmp", 32'd100);
        wr(32'h04, 32'd1, 4'hF);
        check("w1c_irq", 32'(irq), 32'd0);
        rd(32'h04, "oneshot_status_clr", 32'd0);

        // periodic reload across the 32-bit wrap on channel 1
        do_reset();
        count_in = 32'hFFFF_FFE0;
        wr(32'h18, 32'hFFFF_FFF0, 4'hF);
        wr(32'h1C, 32'h0000_0020, 4'hF);
        wr(32'h08, 32'd2, 4'hF);
        push_exp("periodic_match1", 32'hFFFF_FFF0);
        wr(32'h00, 32'd2, 4'hF);
        wait_irq(64);
        rd(32'h18, "periodic_cmp1", 32'h0000_0010);
        push_exp("periodic_match2", 32'h0000_0010);
        wr(32'h04, 32'd2, 4'hF);
        check("periodic_irq_clr", 32'(irq), 32'd0);
        wait_irq(64);
        rd(32'h18, "periodic_cmp2", 32'h0000_0030);
        rd(32'h00, "periodic_ctrl", 32'd2);

        // W1C landing on the match edge of channel 2
        do_reset();
        count_in = 32'd200;
        wr(32'h20, 32'd300, 4'hF);
        wr(32'h24, 32'd0, 4'hF);
        wr(32'h00, 32'd4, 4'hF);
        k = 0;
        while (count_in != 32'd300 && k < 200) begin
            tick();
            k++;
        end
        check("collide_count", count_in, 32'd300);
        wr(32'h04, 32'd4, 4'hF);
        check("collide_irq_masked", 32'(irq), 32'd0);
        rd(32'h04, "collide_status", 32'd4);
        wr(32'h04, 32'd4, 4'hF);
        rd(32'h04, "status_after_w1c", 32'd0);

        // byte strobes on channel 3
        wr(32'h28, 32'hAABB_CCDD, 4'b0010);
        rd(32'h28, "strobe_cmp3", 32'h0000_CC00);
        wr(32'h28, 32'h1122_3344, 4'b1001);
        rd(32'h28, "strobe_cmp3_b", 32'h1100_CC44);

        // chip select low: no ack, no data, no register change
        wr(32'h08, 32'd3, 4'hF);
        rd(32'h28, "cs_prime", 32'h1100_CC44);
        enable    = 1'b0;
        mem_valid = 1'b1;
        mem_addr  = 32'h08;
        mem_wdata = 32'h0;
        mem_wstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("cs_ready", 32'(mem_ready), 32'd0);
            check("cs_rdata", mem_rdata, 32'd0);
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        rd(32'h08, "cs_irqen_kept", 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
